// File: rtl/ysyx_23060203_aclint_pkg.sv
// ysyx_23060203_aclint_pkg: register map, FSM state types and byte-lane merge helper
package ysyx_23060203_aclint_pkg;
    localparam logic [15:0] MSIP_BASE = 16'h0000;
    localparam logic [15:0] MTIMECMP_BASE = 16'h4000;
    localparam logic [15:0] MTIME_LO = 16'hBFF8;
    localparam logic [15:0] MTIME_HI = 16'hBFFC;
    typedef enum logic {R_IDLE, R_RESP} rstate_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_ADDR, W_RESP} wstate_t;
    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] strb);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b+:8] = strb[b] ? d[8*b+:8] : old[8*b+:8];
        return r;
    endfunction
endpackage

// File: rtl/ysyx_23060203_aclint_if.sv
// axi_if: 32-bit AXI-lite style bus; "in" is the slave view, "out" the master view
interface axi_if;
    logic [31:0] araddr;
    logic        arvalid, arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid, rready, rlast;
    logic [3:0]  rid;
    logic [31:0] awaddr;
    logic        awvalid, awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid, wready;
    logic [1:0]  bresp;
    logic        bvalid, bready;
    logic [3:0]  bid;
    modport in (input araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
                output arready, rdata, rresp, rvalid, rlast, rid, awready, wready, bresp, bvalid, bid);
    modport out (output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
                 input arready, rdata, rresp, rvalid, rlast, rid, awready, wready, bresp, bvalid, bid);
endinterface

// File: rtl/ysyx_23060203_aclint_timer.sv
// ysyx_23060203_aclint_timer: prescaled free-running 64-bit mtime with byte-strobed word writes
module ysyx_23060203_aclint_timer
    import ysyx_23060203_aclint_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        we_lo,
    input  logic        we_hi,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic [63:0] mtime
);
    logic [31:0] cnt;
    logic        tick;
    logic [63:0] inc;
    assign tick = cnt == 32'(PRESCALE - 1);
    assign inc = mtime + {63'd0, tick};
    // unwritten bytes of a written word still advance with the tick
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt <= '0;
            mtime <= '0;
        end else begin
            cnt <= tick ? '0 : cnt + 32'd1;
            mtime <= {we_hi ? merge(inc[63:32], wdata, wstrb) : inc[63:32],
                      we_lo ? merge(inc[31:0], wdata, wstrb) : inc[31:0]};
        end
    end
endmodule

// File: rtl/ysyx_23060203_aclint.sv
// ysyx_23060203_aclint: core-local interruptor (mtime, per-hart mtimecmp/msip) behind AXI slave ports
module ysyx_23060203_aclint
    import ysyx_23060203_aclint_pkg::*;
#(
    parameter int NHART = 1,
    parameter int PRESCALE = 1,
    parameter int ADDR_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    output logic [NHART-1:0] mtip,
    output logic [NHART-1:0] msip,
    axi_if.in                read,
    axi_if.in                write
);
    rstate_t rs, rs_n;
    wstate_t ws, ws_n;
    logic [63:0] mtime;
    logic [63:0] cmp [NHART];
    logic [NHART-1:0] msip_r, mtip_r;
    logic [ADDR_W-1:0] aw_q, waddr, raddr;
    logic [31:0] wd_q, wd, rd, rdata_q;
    logic [3:0] wst_q, wst;
    logic commit;

    ysyx_23060203_aclint_timer #(.PRESCALE(PRESCALE)) u_timer (
        .clock(clock), .reset(reset),
        .we_lo(commit && waddr == ADDR_W'(MTIME_LO)),
        .we_hi(commit && waddr == ADDR_W'(MTIME_HI)),
        .wdata(wd), .wstrb(wst), .mtime(mtime)
    );

    always_comb begin
        raddr = read.araddr[ADDR_W-1:0];
        rd = '0;
        if (raddr == ADDR_W'(MTIME_LO)) rd = mtime[31:0];
        if (raddr == ADDR_W'(MTIME_HI)) rd = mtime[63:32];
        for (int h = 0; h < NHART; h++) begin
            if (raddr == ADDR_W'(MSIP_BASE + 4 * h)) rd = {31'd0, msip_r[h]};
            if (raddr == ADDR_W'(MTIMECMP_BASE + 8 * h)) rd = cmp[h][31:0];
            if (raddr == ADDR_W'(MTIMECMP_BASE + 8 * h + 4)) rd = cmp[h][63:32];
        end
    end

    always_comb begin
        rs_n = rs;
        if (rs == R_IDLE && read.arvalid) rs_n = R_RESP;
        if (rs == R_RESP && read.rready) rs_n = R_IDLE;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rs <= R_IDLE;
            rdata_q <= '0;
        end else begin
            rs <= rs_n;
            if (rs == R_IDLE && read.arvalid) rdata_q <= rd;
        end
    end

    assign read.arready = rs == R_IDLE;
    assign read.rvalid = rs == R_RESP;
    assign read.rdata = rdata_q;
    assign read.rresp = '0;
    assign read.rlast = 1'b1;
    assign read.rid = '0;
    assign read.awready = 1'b0;
    assign read.wready = 1'b0;
    assign read.bvalid = 1'b0;
    assign read.bresp = '0;
    assign read.bid = '0;

    always_comb begin
        ws_n = ws;
        commit = 1'b0;
        case (ws)
            W_IDLE: begin
                if (write.awvalid && write.wvalid) begin
                    ws_n = W_RESP;
                    commit = 1'b1;
                end else if (write.awvalid) ws_n = W_DATA;
                else if (write.wvalid) ws_n = W_ADDR;
            end
            W_DATA: if (write.wvalid) begin
                ws_n = W_RESP;
                commit = 1'b1;
            end
            W_ADDR: if (write.awvalid) begin
                ws_n = W_RESP;
                commit = 1'b1;
            end
            W_RESP: if (write.bready) ws_n = W_IDLE;
        endcase
    end

    // the missing half of a split write comes live from the bus, the other from the latch
    assign waddr = ws == W_DATA ? aw_q : write.awaddr[ADDR_W-1:0];
    assign wd = ws == W_ADDR ? wd_q : write.wdata;
    assign wst = ws == W_ADDR ? wst_q : write.wstrb;

    always_ff @(posedge clock) begin
        if (reset) begin
            ws <= W_IDLE;
            aw_q <= '0;
            wd_q <= '0;
            wst_q <= '0;
        end else begin
            ws <= ws_n;
            if (ws == W_IDLE && write.awvalid && !write.wvalid) aw_q <= write.awaddr[ADDR_W-1:0];
            if (ws == W_IDLE && write.wvalid && !write.awvalid) begin
                wd_q <= write.wdata;
                wst_q <= write.wstrb;
            end
        end
    end

    assign write.awready = ws == W_IDLE || ws == W_ADDR;
    assign write.wready = ws == W_IDLE || ws == W_DATA;
    assign write.bvalid = ws == W_RESP;
    assign write.bresp = '0;
    assign write.bid = '0;
    assign write.arready = 1'b0;
    assign write.rvalid = 1'b0;
    assign write.rdata = '0;
    assign write.rresp = '0;
    assign write.rlast = 1'b0;
    assign write.rid = '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            msip_r <= '0;
            mtip_r <= '0;
            for (int h = 0; h < NHART; h++) cmp[h] <= '1;
        end else begin
            for (int h = 0; h < NHART; h++) begin
                mtip_r[h] <= mtime >= cmp[h];
                if (commit && wst[0] && waddr == ADDR_W'(MSIP_BASE + 4 * h)) msip_r[h] <= wd[0];
                if (commit && waddr == ADDR_W'(MTIMECMP_BASE + 8 * h)) cmp[h][31:0] <= merge(cmp[h][31:0], wd, wst);
                if (commit && waddr == ADDR_W'(MTIMECMP_BASE + 8 * h + 4)) cmp[h][63:32] <= merge(cmp[h][63:32], wd, wst);
            end
        end
    end

    assign mtip = mtip_r;
    assign msip = msip_r;
endmodule

// File: tb/tb_ysyx_23060203_aclint.sv
// tb_ysyx_23060203_aclint: random AXI traffic checked against a transaction-level register model
module tb_ysyx_23060203_aclint;
    localparam int NH = 2;
    localparam int PS = 3;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NH-1:0] mtip, msip;
    axi_if rbus ();
    axi_if wbus ();
    int n_cmp = 0;
    int n_bad = 0;
    int n_b = 0;

    ysyx_23060203_aclint #(.NHART(NH), .PRESCALE(PS), .ADDR_W(16)) dut (
        .clock(clk), .reset(rst), .mtip(mtip), .msip(msip), .read(rbus), .write(wbus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // model state: what the registers should hold according to the register map
    logic [63:0] m_time, nt;
    int m_cnt;
    logic [63:0] m_cmp [NH];
    logic [NH-1:0] m_msip, m_mtip;
    logic [31:0] exp_rd;
    logic [31:0] awq [$];
    logic [35:0] wq [$];
    logic [31:0] ma, md;
    logic [3:0] ms;
    int mo;

    function automatic logic [31:0] mread(input logic [31:0] a);
        int o = int'(a[15:0]);
        if (o == 'hBFF8) return m_time[31:0];
        if (o == 'hBFFC) return m_time[63:32];
        if (o % 4 == 0 && o < 4 * NH) return {31'd0, m_msip[o/4]};
        if (o % 4 == 0 && o >= 'h4000 && o < 'h4000 + 8 * NH)
            return (o % 8 != 0) ? m_cmp[(o-'h4000)/8][63:32] : m_cmp[(o-'h4000)/8][31:0];
        return 32'd0;
    endfunction

    function automatic logic [63:0] lane(input logic [63:0] v, input int word, input logic [31:0] d, input logic [3:0] s);
        for (int b = 0; b < 4; b++) if (s[b]) v[32*word+8*b+:8] = d[8*b+:8];
        return v;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_time = 0;
            m_cnt = 0;
            for (int h = 0; h < NH; h++) m_cmp[h] = '1;
            m_msip = '0;
            m_mtip = '0;
            awq.delete();
            wq.delete();
        end else begin
            if (rbus.arvalid && rbus.arready) exp_rd = mread(rbus.araddr);
            if (wbus.bvalid && wbus.bready) n_b++;
            for (int h = 0; h < NH; h++) m_mtip[h] = m_time >= m_cmp[h];
            nt = m_time + ((m_cnt == PS - 1) ? 64'd1 : 64'd0);
            m_cnt = (m_cnt + 1) % PS;
            if (wbus.awvalid && wbus.awready) awq.push_back(wbus.awaddr);
            if (wbus.wvalid && wbus.wready) wq.push_back({wbus.wstrb, wbus.wdata});
            if (awq.size() > 0 && wq.size() > 0) begin
                ma = awq.pop_front();
                {ms, md} = wq.pop_front();
                mo = int'(ma[15:0]);
                if (mo == 'hBFF8) nt = lane(nt, 0, md, ms);
                if (mo == 'hBFFC) nt = lane(nt, 1, md, ms);
                if (mo % 4 == 0 && mo < 4 * NH && ms[0]) m_msip[mo/4] = md[0];
                if (mo % 4 == 0 && mo >= 'h4000 && mo < 'h4000 + 8 * NH)
                    m_cmp[(mo-'h4000)/8] = lane(m_cmp[(mo-'h4000)/8], (mo % 8) / 4, md, ms);
            end
            m_time = nt;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("mtip", 64'(mtip), 64'(m_mtip));
            check("msip", 64'(msip), 64'(m_msip));
        end
    end

    task automatic rd(input logic [31:0] a, input int hold);
        int i = 0;
        rbus.araddr = a;
        rbus.arvalid = 1'b1;
        while (!rbus.arready && i < 20) begin
            @(negedge clk);
            i++;
        end
        check("ar_ready", 64'(rbus.arready), 64'd1);
        @(negedge clk);
        rbus.arvalid = 1'b0;
        repeat (hold) begin
            check("rvalid_hold", 64'(rbus.rvalid), 64'd1);
            check("ar_busy", 64'(rbus.arready), 64'd0);
            check("rdata_hold", 64'(rbus.rdata), 64'(exp_rd));
            @(negedge clk);
        end
        rbus.rready = 1'b1;
        check("rvalid", 64'(rbus.rvalid), 64'd1);
        check("rdata", 64'(rbus.rdata), 64'(exp_rd));
        check("rresp", 64'(rbus.rresp), 64'd0);
        check("rlast", 64'(rbus.rlast), 64'd1);
        @(negedge clk);
        rbus.rready = 1'b0;
        check("rvalid_drop", 64'(rbus.rvalid), 64'd0);
    endtask

    task automatic hs();
        int i = 0;
        while (((wbus.awvalid && !wbus.awready) || (wbus.wvalid && !wbus.wready)) && i < 20) begin
            @(negedge clk);
            i++;
        end
        check("w_hs", 64'(i < 20), 64'd1);
        @(negedge clk);
        wbus.awvalid = 1'b0;
        wbus.wvalid = 1'b0;
    endtask

    // ord: 0 AW+W together, 1 W leads AW by 3 cycles, 2 AW leads W by 3 cycles
    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input int ord, input int hold);
        int nb = n_b;
        int i = 0;
        if (ord != 1) begin
            wbus.awaddr = a;
            wbus.awvalid = 1'b1;
        end
        if (ord != 2) begin
            wbus.wdata = d;
            wbus.wstrb = s;
            wbus.wvalid = 1'b1;
        end
        hs();
        if (ord != 0) begin
            repeat (2) begin
                check("aw_ready_split", 64'(wbus.awready), 64'(ord == 1));
                check("w_ready_split", 64'(wbus.wready), 64'(ord == 2));
                check("no_early_b", 64'(wbus.bvalid), 64'd0);
                @(negedge clk);
            end
            if (ord == 1) begin
                wbus.awaddr = a;
                wbus.awvalid = 1'b1;
            end else begin
                wbus.wdata = d;
                wbus.wstrb = s;
                wbus.wvalid = 1'b1;
            end
            hs();
        end
        repeat (hold) begin
            check("bvalid_hold", 64'(wbus.bvalid), 64'd1);
            check("aw_busy", 64'(wbus.awready), 64'd0);
            check("w_busy", 64'(wbus.wready), 64'd0);
            @(negedge clk);
        end
        wbus.bready = 1'b1;
        while (!wbus.bvalid && i < 20) begin
            @(negedge clk);
            i++;
        end
        check("bvalid", 64'(wbus.bvalid), 64'd1);
        check("bresp", 64'(wbus.bresp), 64'd0);
        check("bid", 64'(wbus.bid), 64'd0);
        @(negedge clk);
        wbus.bready = 1'b0;
        check("b_beats", 64'(n_b - nb), 64'd1);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] up = $urandom;
        int h = $urandom_range(0, NH);
        case ($urandom_range(0, 6))
            0: return {up[31:16], 16'(4 * h)};
            1: return {up[31:16], 16'('h4000 + 8 * h)};
            2: return {up[31:16], 16'('h4004 + 8 * h)};
            3: return {up[31:16], 16'hBFF8};
            4: return {up[31:16], 16'hBFFC};
            5: return {up[31:16], 16'h2000};
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rbus.araddr = '0; rbus.arvalid = 1'b0; rbus.rready = 1'b0;
        rbus.awaddr = '0; rbus.awvalid = 1'b0; rbus.wdata = '0; rbus.wstrb = '0; rbus.wvalid = 1'b0; rbus.bready = 1'b0;
        wbus.araddr = '0; wbus.arvalid = 1'b0; wbus.rready = 1'b0;
        wbus.awaddr = '0; wbus.awvalid = 1'b0; wbus.wdata = '0; wbus.wstrb = '0; wbus.wvalid = 1'b0; wbus.bready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_arready", 64'(rbus.arready), 64'd1);
        check("rst_rvalid", 64'(rbus.rvalid), 64'd0);
        check("rst_awready", 64'(wbus.awready), 64'd1);
        check("rst_wready", 64'(wbus.wready), 64'd1);
        check("rst_bvalid", 64'(wbus.bvalid), 64'd0);
        check("rst_rdata", 64'(rbus.rdata), 64'd0);
        check("rst_mtip", 64'(mtip), 64'd0);
        check("rst_msip", 64'(msip), 64'd0);
        rd(32'hBFF8, 0);
        rd(32'hBFF8, 3);
        rd(32'hBFFC, 1);
        wr(32'h4000, 32'd100, 4'hF, 0, 0);
        wr(32'h4004, 32'd0, 4'hF, 0, 0);
        for (int i = 0; i < 1000 && m_time < 64'd102; i++) @(negedge clk);
        check("mtip_up", 64'(mtip[0]), 64'd1);
        wr(32'h4004, 32'd1, 4'hF, 1, 0);
        check("mtip_down", 64'(mtip[0]), 64'd0);
        wr(32'h0004, 32'd1, 4'hF, 2, 0);
        check("msip_set", 64'(msip), 64'd2);
        wr(32'h0004, 32'd0, 4'h0, 0, 0);
        check("msip_nostrb", 64'(msip), 64'd2);
        rd(32'h0004, 0);
        wr(32'h400C, $urandom, 4'b0101, 1, 5);
        wr(32'h4008, $urandom, 4'b1010, 2, 0);
        wr(32'h4008, $urandom, 4'hF, 0, 5);
        rd(32'h4008, 0);
        rd(32'h400C, 2);
        wr(32'h4000, 32'd0, 4'hF, 0, 0);
        wr(32'h4004, 32'd0, 4'hF, 0, 0);
        wr(32'hBFFC, 32'hFFFF_FFFF, 4'hF, 0, 0);
        wr(32'hBFF8, 32'hFFFF_FFFF, 4'hF, 0, 0);
        rd(32'hBFFC, 0);
        rd(32'hBFF8, 0);
        check("mtip_wrap", 64'(mtip[0]), 64'd1);
        rd(32'h2000, 0);
        check("unmap_rd", 64'(rbus.rdata), 64'd0);
        wr(32'h2000, $urandom, 4'hF, 0, 0);
        rd(32'h4000, 0);
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 2) == 0) rd(rand_addr(), $urandom_range(0, 2));
            else wr(rand_addr(), $urandom, 4'($urandom), $urandom_range(0, 2), $urandom_range(0, 2));
        end
        wbus.awaddr = 32'h4000;
        wbus.awvalid = 1'b1;
        hs();
        check("wdata_state_aw", 64'(wbus.awready), 64'd0);
        check("wdata_state_w", 64'(wbus.wready), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_awready", 64'(wbus.awready), 64'd1);
        check("abort_wready", 64'(wbus.wready), 64'd1);
        check("abort_bvalid", 64'(wbus.bvalid), 64'd0);
        wr(32'h4004, 32'h0, 4'hF, 2, 0);
        rd(32'h4004, 0);
        rd(32'h4000, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1);
    end
endmodule
